pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline.
- Drives the write enables and NOP-insert selects of the F/D, D/X, X/M and M/W latches and the PC register.
- Detects load-use hazards and squashes wrong-path instructions on taken branches.
- Sequences multi-cycle mult/div through a small FSM with a watchdog, and generates the rStatus write (isRStatus/rStatus) carried by the X/M latch.

Parameters:
- MD_TIMEOUT, 64: max cycles spent in MD_BUSY before forced completion.
- TIMEOUT_CODE, 6: rStatus value written on watchdog expiry.

Ports:
- clock  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-high.
- fd_ir  in  32  instruction in F/D latch (decode stage).
- dx_ir  in  32  instruction in D/X latch (execute stage).
- branch_taken  in  1  X-stage branch/jump resolved taken this cycle.
- md_ready  in  1  mult/div unit result valid (single-cycle pulse).
- md_exception  in  1  mult/div error; valid only with md_ready.
- pc_en  out  1  PC write enable.
- fd_en  out  1  F/D latch enable.
- dx_en  out  1  D/X latch enable.
- xm_en  out  1  X/M latch enable.
- mw_en  out  1  M/W latch enable.
- fd_nop  out  1  F/D latch input forced to 0 (NOP).
- dx_nop  out  1  D/X latch input forced to 0.
- xm_nop  out  1  X/M latch input forced to 0.
- md_start  out  1  start pulse to mult/div unit.
- md_sel  out  1  X/M O-input muxes mult/div result instead of ALU.
- status_wr  out  1  drives isRStatus_in of X/M latch.
- status_val  out  32  drives rStatus_in of X/M latch.
- busy  out  1  high while state = MD_BUSY.

Behaviour:
- Decode fields: opcode = ir[31:27], rd = ir[26:22], rs = ir[21:17], rt = ir[16:12], aluop = ir[6:2].
- md_op(dx): opcode 00000 with aluop 00110 (mult) or 00111 (div).
- fd source registers:
  - rs read by opcodes 00000, 00101, 00111, 01000, 00010, 00110.
  - rt read by 00000.
  - rd read by 00111, 00010, 00110, 00100.
- load_use = dx opcode 01000, dx rd != 0, and dx rd equals any register fd reads.
- FSM states: RUN, MD_BUSY. Reset → RUN, wait counter = 0, all outputs 0 except the enables, which are 1.
- RUN, default: all enables 1, all nops 0.
- RUN, priority 1, branch_taken: fd_nop = dx_nop = 1, all enables 1. load_use is ignored that cycle.
- RUN, priority 2, md_op(dx):
  - md_start = 1; pc_en = fd_en = dx_en = 0; xm_nop = 1; xm_en = mw_en = 1.
  - Next state MD_BUSY, counter cleared.
- RUN, priority 3, load_use: pc_en = fd_en = 0, dx_nop = 1, xm_en = mw_en = dx_en = 1. Exactly one bubble per load-use pair.
- MD_BUSY, md_ready = 0 and counter < MD_TIMEOUT-1:
  - Same enables/nops as the md_start cycle, but md_start = 0.
  - busy = 1; counter increments.
- MD_BUSY, md_ready = 1:
  - All enables 1, nops 0, md_sel = 1 → RUN.
  - If md_exception: status_wr = 1; status_val = 4 for mult, 5 for div.
- MD_BUSY, counter = MD_TIMEOUT-1 without md_ready:
  - Forced completion: treated as md_ready with md_exception, but status_val = TIMEOUT_CODE.
  - md_sel = 1; result value is don't-care.
  - → RUN.
- md_ready while in RUN is ignored (no output change).
- status_val is 0 whenever status_wr = 0.
- Outputs are combinational from state, counter and inputs. Only state and counter are registered, on the rising clock edge.
- Back-to-back mult/div: the second starts in the RUN cycle directly after completion, with exactly one md_start per instruction.
- Reset asserted mid-MD_BUSY: immediate return to RUN, counter = 0, md_start not re-issued until the next md_op seen in RUN.

Test Plan:
- Reset, then fd = add, dx = add, no branch → all enables 1, nops 0, busy 0, status_wr 0.
- dx = lw $5 (opcode 01000, rd 5); fd = add $3,$5,$2 → one cycle with pc_en = fd_en = 0 and dx_nop = 1; next cycle the add advances normally.
- Same hazard but with branch_taken = 1 in that cycle → fd_nop = dx_nop = 1, pc_en = 1, no stall.
- dx = mult; md_ready after 3 busy cycles → md_start for 1 cycle, busy for 3 cycles with xm_nop = 1, then md_sel = 1, status_wr = 0, state RUN.
- dx = div; md_ready with md_exception → status_wr = 1, status_val = 5. Mult variant → status_val = 4.
- MD_TIMEOUT = 8, md_ready never asserted → forced completion after 8 cycles in MD_BUSY with status_val = 6. Reset pulsed at busy cycle 3 in a separate run → busy drops immediately, counter 0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Central stall/flush sequencer for the 5-stage pipeline. It drives the write
//   enables and NOP-insert selects of the F/D, D/X, X/M and M/W latches and the
//   PC register. It detects load-use hazards and squashes wrong-path
//   instructions on taken branches. A two-state FSM with a watchdog sequences
//   multi-cycle mult/div operations, and the block generates the rStatus write
//   that the X/M latch carries.
//
// Parameters
//   MD_TIMEOUT    max cycles spent in MD_BUSY before completion is forced
//   TIMEOUT_CODE  rStatus value written when the watchdog expires
//
// Ports
//   clock, reset        rising-edge clock, asynchronous active-high reset
//   fd_ir, dx_ir        instructions in the F/D (decode) and D/X (execute) latches
//   branch_taken        X-stage branch/jump resolved taken this cycle
//   md_ready            mult/div result valid (single-cycle pulse)
//   md_exception        mult/div error, meaningful only together with md_ready
//   pc_en, fd_en, dx_en, xm_en, mw_en   latch / PC write enables
//   fd_nop, dx_nop, xm_nop              force the latch input to 0 (NOP)
//   md_start            start pulse to the mult/div unit
//   md_sel              X/M O-input takes the mult/div result instead of the ALU
//   status_wr           isRStatus_in of the X/M latch
//   status_val          rStatus_in of the X/M latch (0 when status_wr is 0)
//   busy                high while the FSM is in MD_BUSY
module pipeline_hazard_ctrl #(
  parameter int MD_TIMEOUT   = 64,
  parameter int TIMEOUT_CODE = 6
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] fd_ir,
  input  logic [31:0] dx_ir,
  input  logic        branch_taken,
  input  logic        md_ready,
  input  logic        md_exception,
  output logic        pc_en,
  output logic        fd_en,
  output logic        dx_en,
  output logic        xm_en,
  output logic        mw_en,
  output logic        fd_nop,
  output logic        dx_nop,
  output logic        xm_nop,
  output logic        md_start,
  output logic        md_sel,
  output logic        status_wr,
  output logic [31:0] status_val,
  output logic        busy
);

  localparam int CW = (MD_TIMEOUT > 2) ? $clog2(MD_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MD_TIMEOUT - 1);

  typedef enum logic {RUN, MD_BUSY} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;

  // Instruction field decode
  logic [4:0] fd_op, fd_rd, fd_rs, fd_rt;
  logic [4:0] dx_op, dx_rd, dx_aluop;

  assign fd_op    = fd_ir[31:27];
  assign fd_rd    = fd_ir[26:22];
  assign fd_rs    = fd_ir[21:17];
  assign fd_rt    = fd_ir[16:12];
  assign dx_op    = dx_ir[31:27];
  assign dx_rd    = dx_ir[26:22];
  assign dx_aluop = dx_ir[6:2];

  logic unused_ir_bits;
  assign unused_ir_bits = ^{fd_ir[11:0], dx_ir[21:7], dx_ir[1:0]};

  logic dx_is_md, dx_is_div;
  assign dx_is_md  = (dx_op == 5'b00000) &&
                     ((dx_aluop == 5'b00110) || (dx_aluop == 5'b00111));
  assign dx_is_div = (dx_aluop == 5'b00111);

  // Which registers the decode-stage instruction reads, selected by opcode
  logic fd_reads_rs, fd_reads_rt, fd_reads_rd;
  always_comb begin
    fd_reads_rs = 1'b0;
    fd_reads_rt = 1'b0;
    fd_reads_rd = 1'b0;
    unique case (fd_op)
      5'b00000: begin fd_reads_rs = 1'b1; fd_reads_rt = 1'b1; end
      5'b00101: fd_reads_rs = 1'b1;
      5'b01000: fd_reads_rs = 1'b1;
      5'b00111: begin fd_reads_rs = 1'b1; fd_reads_rd = 1'b1; end
      5'b00010: begin fd_reads_rs = 1'b1; fd_reads_rd = 1'b1; end
      5'b00110: begin fd_reads_rs = 1'b1; fd_reads_rd = 1'b1; end
      5'b00100: fd_reads_rd = 1'b1;
      default: ;
    endcase
  end

  logic load_use;
  assign load_use = (dx_op == 5'b01000) && (dx_rd != 5'd0) &&
                    ((fd_reads_rs && (fd_rs == dx_rd)) ||
                     (fd_reads_rt && (fd_rt == dx_rd)) ||
                     (fd_reads_rd && (fd_rd == dx_rd)));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    pc_en      = 1'b1;
    fd_en      = 1'b1;
    dx_en      = 1'b1;
    xm_en      = 1'b1;
    mw_en      = 1'b1;
    fd_nop     = 1'b0;
    dx_nop     = 1'b0;
    xm_nop     = 1'b0;
    md_start   = 1'b0;
    md_sel     = 1'b0;
    status_wr  = 1'b0;
    status_val = '0;
    busy       = 1'b0;

    unique case (state)
      RUN: begin
        if (branch_taken) begin
          fd_nop = 1'b1;
          dx_nop = 1'b1;
        end else if (dx_is_md) begin
          md_start = 1'b1;
          pc_en    = 1'b0;
          fd_en    = 1'b0;
          dx_en    = 1'b0;
          xm_nop   = 1'b1;
          state_n  = MD_BUSY;
          cnt_n    = '0;
        end else if (load_use) begin
          pc_en  = 1'b0;
          fd_en  = 1'b0;
          dx_nop = 1'b1;
        end
      end
      MD_BUSY: begin
        busy = 1'b1;
        if (md_ready || (cnt == CNT_LAST)) begin
          // The op is still held in D/X (dx_en was low), so dx_ir tells mult from div.
          md_sel  = 1'b1;
          state_n = RUN;
          cnt_n   = '0;
          if (!md_ready) begin
            status_wr  = 1'b1;
            status_val = 32'(TIMEOUT_CODE);
          end else if (md_exception) begin
            status_wr  = 1'b1;
            status_val = dx_is_div ? 32'd5 : 32'd4;
          end
        end else begin
          pc_en  = 1'b0;
          fd_en  = 1'b0;
          dx_en  = 1'b0;
          xm_nop = 1'b1;
          cnt_n  = cnt + 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: the stimulus process pushes the
// hand-computed output vector for each cycle, and the monitor pops and compares
// at the falling edge.
module tb_pipeline_hazard_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] fd_ir, dx_ir;
  logic        branch_taken, md_ready, md_exception;
  logic        pc_en, fd_en, dx_en, xm_en, mw_en;
  logic        fd_nop, dx_nop, xm_nop, md_start, md_sel, status_wr, busy;
  logic [31:0] status_val;

  pipeline_hazard_ctrl #(.MD_TIMEOUT(8), .TIMEOUT_CODE(6)) dut (
    .clock(clock), .reset(reset), .fd_ir(fd_ir), .dx_ir(dx_ir),
    .branch_taken(branch_taken), .md_ready(md_ready), .md_exception(md_exception),
    .pc_en(pc_en), .fd_en(fd_en), .dx_en(dx_en), .xm_en(xm_en), .mw_en(mw_en),
    .fd_nop(fd_nop), .dx_nop(dx_nop), .xm_nop(xm_nop), .md_start(md_start),
    .md_sel(md_sel), .status_wr(status_wr), .status_val(status_val), .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [43:0] v;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Flag order: pc fd dx xm mw | fd_nop dx_nop xm_nop | md_start md_sel status_wr busy
  localparam logic [11:0] RUNV   = 12'b11111_000_0000;
  localparam logic [11:0] STALL  = 12'b00111_010_0000;
  localparam logic [11:0] BRV    = 12'b11111_110_0000;
  localparam logic [11:0] MDS    = 12'b00011_001_1000;
  localparam logic [11:0] MDW    = 12'b00011_001_0001;
  localparam logic [11:0] DONE   = 12'b11111_000_0101;
  localparam logic [11:0] DONE_E = 12'b11111_000_0111;

  function automatic logic [31:0] ins(input logic [4:0] op, rd, rs, rt, aluop);
    return {op, rd, rs, rt, 5'b00000, aluop, 2'b00};
  endfunction

  logic [31:0] ADD_A, ADD_B, ADD_RT, LW5, LW0, ADD_R0, SW5, J5, MULT, DIV;

  task automatic step(input logic rst_v, input logic [31:0] f, d,
                      input logic br, rdy, exc,
                      input logic [11:0] fl, input logic [31:0] sv, input string nm);
    @(posedge clock);
    #1;
    reset        = rst_v;
    fd_ir        = f;
    dx_ir        = d;
    branch_taken = br;
    md_ready     = rdy;
    md_exception = exc;
    exp_q.push_back('{v: {fl, sv}, name: nm});
  endtask

  // Monitor
  initial begin
    exp_t        e;
    logic [43:0] act;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        act = {pc_en, fd_en, dx_en, xm_en, mw_en, fd_nop, dx_nop, xm_nop,
               md_start, md_sel, status_wr, busy, status_val};
        checks++;
        if (act !== e.v) begin
          errors++;
          $display("FAIL %s: got flags %b val %0d, expected flags %b val %0d",
                   e.name, act[43:32], act[31:0], e.v[43:32], e.v[31:0]);
        end
      end
    end
  end

  initial begin
    ADD_A  = ins(5'b00000, 5'd3, 5'd5, 5'd2, 5'd0);   // add $3,$5,$2
    ADD_B  = ins(5'b00000, 5'd1, 5'd2, 5'd3, 5'd0);   // add $1,$2,$3
    ADD_RT = ins(5'b00000, 5'd3, 5'd1, 5'd5, 5'd0);   // add $3,$1,$5
    ADD_R0 = ins(5'b00000, 5'd3, 5'd0, 5'd0, 5'd0);   // add $3,$0,$0
    LW5    = ins(5'b01000, 5'd5, 5'd1, 5'd0, 5'd0);   // lw $5
    LW0    = ins(5'b01000, 5'd0, 5'd1, 5'd0, 5'd0);   // lw $0
    SW5    = ins(5'b00111, 5'd5, 5'd1, 5'd0, 5'd0);   // reads rd=$5
    J5     = ins(5'b00001, 5'd0, 5'd5, 5'd5, 5'd0);   // reads nothing
    MULT   = ins(5'b00000, 5'd4, 5'd1, 5'd2, 5'd6);
    DIV    = ins(5'b00000, 5'd4, 5'd1, 5'd2, 5'd7);

    reset = 1'b1; fd_ir = ADD_A; dx_ir = ADD_B;
    branch_taken = 1'b0; md_ready = 1'b0; md_exception = 1'b0;

    step(1, ADD_A, ADD_B, 0, 0, 0, RUNV, 0, "reset_state");
    step(0, ADD_A, ADD_B, 0, 0, 0, RUNV, 0, "run_default");

    // Load-use hazards
    step(0, ADD_A,  LW5, 0, 0, 0, STALL, 0, "lu_rs_stall");
    step(0, ADD_A,  '0,  0, 0, 0, RUNV,  0, "lu_rs_advance");
    step(0, ADD_RT, LW5, 0, 0, 0, STALL, 0, "lu_rt_stall");
    step(0, SW5,    LW5, 0, 0, 0, STALL, 0, "lu_rd_stall");
    step(0, J5,     LW5, 0, 0, 0, RUNV,  0, "lu_no_read");
    step(0, ADD_R0, LW0, 0, 0, 0, RUNV,  0, "lu_r0_ignored");
    step(0, ADD_A,  LW5, 1, 0, 0, BRV,   0, "branch_over_lu");

    // mult, 3 wait cycles, clean completion
    step(0, ADD_A, MULT, 0, 0, 0, MDS, 0, "mult_start");
    for (int unsigned i = 0; i < 3; i++)
      step(0, ADD_A, MULT, 0, 0, 0, MDW, 0, "mult_wait");
    step(0, ADD_A, MULT, 0, 1, 0, DONE, 0, "mult_done");
    step(0, ADD_A, ADD_B, 0, 1, 1, RUNV, 0, "ready_in_run_ignored");

    // div with exception
    step(0, ADD_A, DIV, 0, 0, 0, MDS, 0, "div_start");
    step(0, ADD_A, DIV, 0, 0, 0, MDW, 0, "div_wait");
    step(0, ADD_A, DIV, 0, 1, 1, DONE_E, 5, "div_exc");

    // mult with exception, then back-to-back div
    step(0, ADD_A, MULT, 0, 0, 0, MDS, 0, "mult2_start");
    step(0, ADD_A, MULT, 0, 1, 1, DONE_E, 4, "mult_exc");
    step(0, ADD_A, DIV,  0, 0, 0, MDS, 0, "b2b_div_start");
    step(0, ADD_A, DIV,  0, 1, 0, DONE, 0, "b2b_div_done");

    // Watchdog expiry: 7 waits, forced completion on the 8th busy cycle
    step(0, ADD_A, MULT, 0, 0, 0, MDS, 0, "to_start");
    for (int unsigned i = 0; i < 7; i++)
      step(0, ADD_A, MULT, 0, 0, 0, MDW, 0, "to_wait");
    step(0, ADD_A, MULT, 0, 0, 0, DONE_E, 6, "to_forced");
    step(0, ADD_A, ADD_B, 0, 0, 0, RUNV, 0, "to_back_run");

    // Reset in the middle of MD_BUSY
    step(0, ADD_A, DIV, 0, 0, 0, MDS, 0, "rst_div_start");
    step(0, ADD_A, DIV, 0, 0, 0, MDW, 0, "rst_div_wait");
    step(0, ADD_A, DIV, 0, 0, 0, MDW, 0, "rst_div_wait");
    step(1, ADD_A, ADD_B, 0, 0, 0, RUNV, 0, "rst_mid_busy");
    step(0, ADD_A, ADD_B, 0, 0, 0, RUNV, 0, "rst_release");
    // A fresh op must get the full 8-cycle budget, so the counter restarted at 0
    step(0, ADD_A, MULT, 0, 0, 0, MDS, 0, "rst_cnt_start");
    for (int unsigned i = 0; i < 7; i++)
      step(0, ADD_A, MULT, 0, 0, 0, MDW, 0, "rst_cnt_wait");
    step(0, ADD_A, MULT, 0, 0, 0, DONE_E, 6, "rst_cnt_forced");

    // Drain the scoreboard with a bounded wait
    for (int unsigned i = 0; i < 4 && exp_q.size() > 0; i++)
      @(negedge clock);
    #1;
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
